// File: rtl/axi4l_master_pkg.sv
// rtl/axi4l_master_pkg.sv - shared states, status codes, cmd fields and size helpers for axi4_lite_master
// Contents:
//   ST_*            FSM state encodings
//   STATUS_*        result codes reported on axi_status
//   CMD_*           bit positions inside the cmd byte
//   size_e          per-beat transfer size
//   bytes_per_size  bytes moved per beat for a given size
package axi4l_master_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_CHECK        = 3'd1;
  localparam logic [2:0] ST_WR_ADDR_DATA = 3'd2;
  localparam logic [2:0] ST_WR_RESP      = 3'd3;
  localparam logic [2:0] ST_RD_ADDR      = 3'd4;
  localparam logic [2:0] ST_RD_DATA      = 3'd5;
  localparam logic [2:0] ST_NEXT         = 3'd6;
  localparam logic [2:0] ST_DONE         = 3'd7;

  localparam logic [7:0] STATUS_OK       = 8'h00;
  localparam logic [7:0] STATUS_SLVERR   = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT  = 8'h02;
  localparam logic [7:0] STATUS_MISALIGN = 8'h03;
  localparam logic [7:0] STATUS_ILL_SIZE = 8'h04;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_INC_BIT  = 6;
  localparam int CMD_SIZE_MSB = 5;
  localparam int CMD_SIZE_LSB = 4;
  localparam int CMD_LEN_MSB  = 3;
  localparam int CMD_LEN_LSB  = 0;

  typedef enum logic [1:0] {
    SIZE_8   = 2'b00,
    SIZE_16  = 2'b01,
    SIZE_32  = 2'b10,
    SIZE_ILL = 2'b11
  } size_e;

  function automatic logic [2:0] bytes_per_size(input size_e s);
    case (s)
      SIZE_8:  return 3'd1;
      SIZE_16: return 3'd2;
      SIZE_32: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// rtl/axi4_lite_if.sv - AXI4-Lite signal bundle with master and slave modports
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//           R (rdata/rresp/rvalid/rready)
interface axi4_lite_if;

  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/address_aligner.sv
// rtl/address_aligner.sv - per-beat address alignment, byte lane and write strobe generation
// Ports:
//   i_size      beat size from cmd
//   i_addr      current beat byte address
//   o_addr      address with low bits cleared to the size boundary
//   o_wstrb     write strobes for the beat
//   o_lane      first byte lane used on the 32-bit data bus
//   o_misalign  address not on a size boundary (only when AXI4L_MASTER_ALIGN_CHECK_EN is defined)
module address_aligner
  import axi4l_master_pkg::*;
(
  input  size_e       i_size,
  input  logic [31:0] i_addr,
  output logic [31:0] o_addr,
  output logic [3:0]  o_wstrb,
  output logic [1:0]  o_lane,
  output logic        o_misalign
);

  always_comb begin
    o_addr     = i_addr;
    o_wstrb    = 4'b0000;
    o_lane     = i_addr[1:0];
    o_misalign = 1'b0;
    case (i_size)
      SIZE_8: begin
        o_wstrb = 4'b0001 << i_addr[1:0];
      end
      SIZE_16: begin
        // Without the check the halfword is forced onto its boundary,
        // so the lane follows the forced address, not the raw one.
        o_addr  = {i_addr[31:1], 1'b0};
        o_lane  = {i_addr[1], 1'b0};
        o_wstrb = 4'b0011 << {i_addr[1], 1'b0};
`ifdef AXI4L_MASTER_ALIGN_CHECK_EN
        o_misalign = i_addr[0];
`endif
      end
      SIZE_32: begin
        o_addr  = {i_addr[31:2], 2'b00};
        o_lane  = 2'b00;
        o_wstrb = 4'b1111;
`ifdef AXI4L_MASTER_ALIGN_CHECK_EN
        o_misalign = |i_addr[1:0];
`endif
      end
      default: begin
        o_wstrb = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - command-driven AXI4-Lite master issuing 1-16 single beats per frame
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cmd                 [7]=read, [6]=increment address, [5:4]=size, [3:0]=beats-1
//   addr                start byte address
//   write_data          write payload, beat b byte k at index b*bytes+k
//   start_transaction   start pulse, honoured in IDLE only
//   transaction_done    one-cycle completion pulse
//   axi_status          result code, held from done until the next transaction
//   read_data           captured read bytes, same packing as write_data
//   read_data_count     bytes captured, saturating at 63
//   axi                 AXI4-Lite master port, prot tied to 3'b000
// Build option: AXI4L_MASTER_ALIGN_CHECK_EN makes misaligned 16/32-bit
// requests finish with STATUS_MISALIGN instead of being forced aligned.
module axi4_lite_master
  import axi4l_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500,
  parameter int MAX_BYTES      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd,
  input  logic [31:0] addr,
  input  logic [7:0]  write_data [0:MAX_BYTES-1],
  input  logic        start_transaction,
  output logic        transaction_done,
  output logic [7:0]  axi_status,
  output logic [7:0]  read_data [0:MAX_BYTES-1],
  output logic [5:0]  read_data_count,
  axi4_lite_if.master axi
);

  logic [2:0]  r_state;
  logic [7:0]  r_cmd;
  logic [31:0] r_addr;
  logic [3:0]  r_beat;
  logic        r_aw_pend;
  logic        r_w_pend;
  logic [1:0]  r_resp;
  logic [31:0] r_tmo;
  logic [7:0]  r_status;
  logic [5:0]  r_count;
  logic [7:0]  r_read_data [0:MAX_BYTES-1];

  size_e       w_size;
  logic [2:0]  w_bytes;
  logic [31:0] w_aligned_addr;
  logic [3:0]  w_wstrb;
  logic [1:0]  w_lane;
  logic        w_misalign;
  logic [5:0]  w_base;
  logic [31:0] w_wword;
  logic [31:0] w_wdata;
  logic [31:0] w_rword;
  logic [6:0]  w_cnt_sum;
  logic        w_tmo_hit;
  logic        w_aw_left;
  logic        w_w_left;

  assign w_size    = size_e'(r_cmd[CMD_SIZE_MSB:CMD_SIZE_LSB]);
  assign w_bytes   = bytes_per_size(w_size);
  assign w_base    = 6'({2'b00, r_beat} * {3'b000, w_bytes});
  assign w_tmo_hit = (r_tmo == 32'(TIMEOUT_CYCLES - 1));
  assign w_cnt_sum = {1'b0, r_count} + {4'b0000, w_bytes};
  // A channel is still outstanding if it has not handshaken before or in this cycle.
  assign w_aw_left = r_aw_pend && !axi.awready;
  assign w_w_left  = r_w_pend && !axi.wready;

  address_aligner u_aligner (
    .i_size     (w_size),
    .i_addr     (r_addr),
    .o_addr     (w_aligned_addr),
    .o_wstrb    (w_wstrb),
    .o_lane     (w_lane),
    .o_misalign (w_misalign)
  );

  // Gather this beat's payload bytes little-endian, then slide them onto the lane.
  always_comb begin
    w_wword = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_bytes) begin
        w_wword[k*8 +: 8] = write_data[w_base + 6'(k)];
      end
    end
  end

  assign w_wdata = w_wword << {w_lane, 3'b000};
  assign w_rword = axi.rdata >> {w_lane, 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cmd     <= 8'h00;
      r_addr    <= 32'h0;
      r_beat    <= 4'h0;
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
      r_resp    <= 2'b00;
      r_tmo     <= 32'h0;
      r_status  <= STATUS_OK;
      r_count   <= 6'd0;
      for (int i = 0; i < MAX_BYTES; i++) begin
        r_read_data[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_transaction) begin
            r_cmd   <= cmd;
            r_addr  <= addr;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_beat  <= 4'h0;
          r_count <= 6'd0;
          r_tmo   <= 32'h0;
          if (w_size == SIZE_ILL) begin
            r_status <= STATUS_ILL_SIZE;
            r_state  <= ST_DONE;
          end else if (w_misalign) begin
            r_status <= STATUS_MISALIGN;
            r_state  <= ST_DONE;
          end else if (r_cmd[CMD_RW_BIT]) begin
            r_state <= ST_RD_ADDR;
          end else begin
            r_aw_pend <= 1'b1;
            r_w_pend  <= 1'b1;
            r_state   <= ST_WR_ADDR_DATA;
          end
        end
        ST_WR_ADDR_DATA: begin
          if (axi.awready) r_aw_pend <= 1'b0;
          if (axi.wready)  r_w_pend  <= 1'b0;
          if (!w_aw_left && !w_w_left) begin
            r_tmo   <= 32'h0;
            r_state <= ST_WR_RESP;
          end else if (w_tmo_hit) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_status  <= STATUS_TIMEOUT;
            r_state   <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        ST_WR_RESP: begin
          if (axi.bvalid) begin
            r_resp  <= axi.bresp;
            r_state <= ST_NEXT;
          end else if (w_tmo_hit) begin
            r_status <= STATUS_TIMEOUT;
            r_state  <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        ST_RD_ADDR: begin
          if (axi.arready) begin
            r_tmo   <= 32'h0;
            r_state <= ST_RD_DATA;
          end else if (w_tmo_hit) begin
            r_status <= STATUS_TIMEOUT;
            r_state  <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        ST_RD_DATA: begin
          if (axi.rvalid) begin
            r_resp <= axi.rresp;
            for (int k = 0; k < 4; k++) begin
              if (3'(k) < w_bytes) begin
                r_read_data[w_base + 6'(k)] <= w_rword[k*8 +: 8];
              end
            end
            r_count <= (w_cnt_sum > 7'd63) ? 6'd63 : w_cnt_sum[5:0];
            r_state <= ST_NEXT;
          end else if (w_tmo_hit) begin
            r_status <= STATUS_TIMEOUT;
            r_state  <= ST_DONE;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end
        ST_NEXT: begin
          r_tmo <= 32'h0;
          if (r_resp != 2'b00) begin
            r_status <= STATUS_SLVERR;
            r_state  <= ST_DONE;
          end else if (r_beat == r_cmd[CMD_LEN_MSB:CMD_LEN_LSB]) begin
            r_status <= STATUS_OK;
            r_state  <= ST_DONE;
          end else begin
            r_beat <= r_beat + 4'd1;
            if (r_cmd[CMD_INC_BIT]) r_addr <= r_addr + {29'h0, w_bytes};
            if (r_cmd[CMD_RW_BIT]) begin
              r_state <= ST_RD_ADDR;
            end else begin
              r_aw_pend <= 1'b1;
              r_w_pend  <= 1'b1;
              r_state   <= ST_WR_ADDR_DATA;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign axi.awaddr  = w_aligned_addr;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = (r_state == ST_WR_ADDR_DATA) && r_aw_pend;
  assign axi.wdata   = w_wdata;
  assign axi.wstrb   = w_wstrb;
  assign axi.wvalid  = (r_state == ST_WR_ADDR_DATA) && r_w_pend;
  assign axi.bready  = (r_state == ST_WR_RESP);
  assign axi.araddr  = w_aligned_addr;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = (r_state == ST_RD_ADDR);
  assign axi.rready  = (r_state == ST_RD_DATA);

  assign transaction_done = (r_state == ST_DONE);
  assign axi_status       = r_status;
  assign read_data_count  = r_count;
  assign read_data        = r_read_data;

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - scoreboard bench for axi4_lite_master against a register-block slave model
module tb_axi4_lite_master;

  localparam int TMO = 2500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic [31:0] addr = 32'h0;
  logic [7:0] write_data [0:63];
  logic       start = 1'b0;
  logic       done;
  logic [7:0] status;
  logic [7:0] read_data [0:63];
  logic [5:0] rcount;

  always #5 clk = ~clk;

  axi4_lite_if axi_if ();

  axi4_lite_master #(.TIMEOUT_CYCLES(TMO), .MAX_BYTES(64)) dut (
    .clk               (clk),
    .rst               (rst_n),
    .cmd               (cmd),
    .addr              (addr),
    .write_data        (write_data),
    .start_transaction (start),
    .transaction_done  (done),
    .axi_status        (status),
    .read_data         (read_data),
    .read_data_count   (rcount),
    .axi               (axi_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave model: register block with programmable ready delays and error injection.
  int   aw_wait = 0, w_wait = 0;
  bit   bresp_err = 1'b0, stall_ar = 1'b0;
  int   aw_cnt, w_cnt;
  logic s_aw_done, s_w_done;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] mem [0:63];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] ar_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_if.awready <= 1'b0;
      axi_if.wready  <= 1'b0;
      axi_if.bvalid  <= 1'b0;
      axi_if.bresp   <= 2'b00;
      axi_if.arready <= 1'b0;
      axi_if.rvalid  <= 1'b0;
      axi_if.rdata   <= 32'h0;
      axi_if.rresp   <= 2'b00;
      aw_cnt <= 0; w_cnt <= 0;
      s_aw_done <= 1'b0; s_w_done <= 1'b0;
      s_awaddr <= 32'h0; s_wdata <= 32'h0; s_wstrb <= 4'h0;
    end else begin
      if (axi_if.awvalid && axi_if.awready) begin
        axi_if.awready <= 1'b0; s_aw_done <= 1'b1; s_awaddr <= axi_if.awaddr; aw_cnt <= 0;
        aw_q.push_back(axi_if.awaddr);
      end else if (axi_if.awvalid && !s_aw_done) begin
        if (aw_cnt >= aw_wait) axi_if.awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end
      if (axi_if.wvalid && axi_if.wready) begin
        axi_if.wready <= 1'b0; s_w_done <= 1'b1; s_wdata <= axi_if.wdata; s_wstrb <= axi_if.wstrb; w_cnt <= 0;
        w_q.push_back({axi_if.wstrb, axi_if.wdata});
      end else if (axi_if.wvalid && !s_w_done) begin
        if (w_cnt >= w_wait) axi_if.wready <= 1'b1; else w_cnt <= w_cnt + 1;
      end
      if (s_aw_done && s_w_done && !axi_if.bvalid) begin
        for (int k = 0; k < 4; k++)
          if (s_wstrb[k]) mem[s_awaddr[7:2]][k*8 +: 8] <= s_wdata[k*8 +: 8];
        axi_if.bvalid <= 1'b1;
        axi_if.bresp  <= bresp_err ? 2'b10 : 2'b00;
        s_aw_done <= 1'b0; s_w_done <= 1'b0;
      end else if (axi_if.bvalid && axi_if.bready) begin
        axi_if.bvalid <= 1'b0;
      end
      if (axi_if.arvalid && axi_if.arready) begin
        axi_if.arready <= 1'b0;
        ar_q.push_back(axi_if.araddr);
        axi_if.rvalid <= 1'b1;
        axi_if.rdata  <= mem[axi_if.araddr[7:2]];
        axi_if.rresp  <= 2'b00;
      end else if (axi_if.arvalid && !stall_ar && !axi_if.rvalid) begin
        axi_if.arready <= 1'b1;
      end
      if (axi_if.rvalid && axi_if.rready) axi_if.rvalid <= 1'b0;
    end
  end

  // Scoreboard: one expectation per started transaction, compared on the done pulse.
  typedef struct packed {
    logic [7:0]   status;
    logic [5:0]   count;
    logic [2:0]   nwords;
    logic [127:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   done_cnt = 0;
  int   cyc = 0;
  int   lat;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("status", 32'(status), 32'(mon_e.status));
        check("count", 32'(rcount), 32'(mon_e.count));
        for (int w = 0; w < int'(mon_e.nwords); w++)
          check($sformatf("rdata_w%0d", w),
                {read_data[4*w+3], read_data[4*w+2], read_data[4*w+1], read_data[4*w]},
                mon_e.data[32*w +: 32]);
      end
    end
  end

  function automatic exp_t mk(input logic [7:0] st, input logic [5:0] cnt,
                              input logic [2:0] nw, input logic [127:0] d);
    exp_t e;
    e.status = st; e.count = cnt; e.nwords = nw; e.data = d;
    return e;
  endfunction

  task automatic run(input string tag, input logic [7:0] c, input logic [31:0] a,
                     input exp_t e, input int limit);
    int d0, t0;
    aw_q.delete(); w_q.delete(); ar_q.delete();
    sb_q.push_back(e);
    @(negedge clk);
    cmd = c; addr = a; start = 1'b1; d0 = done_cnt; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < limit && done_cnt == d0; i++) @(negedge clk);
    lat = cyc - t0;
    check({"done_", tag}, 32'(done_cnt - d0), 32'd1);
    if (done_cnt == d0 && sb_q.size() > 0) void'(sb_q.pop_back());
    repeat (2) @(negedge clk);
  endtask

  task automatic wr32(input string tag, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) write_data[k] = d[k*8 +: 8];
    run(tag, 8'h20, a, mk(8'h00, 6'd0, 3'd0, 128'h0), 5000);
  endtask

  task automatic rd32(input string tag, input logic [31:0] a, input logic [31:0] d);
    run(tag, 8'hA0, a, mk(8'h00, 6'd4, 3'd1, {96'h0, d}), 5000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) write_data[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'h0);
    check("rst_status", 32'(status), 32'h0);
    check("rst_count", 32'(rcount), 32'h0);
    check("rst_axi_ctrl", 32'({axi_if.awvalid, axi_if.wvalid, axi_if.bready, axi_if.arvalid, axi_if.rready}), 32'h0);
    check("rst_rdata0", 32'(read_data[0]), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    wr32("wr1020", 32'h1020, 32'h12345678);
    check("wr1020_lat", 32'(lat < 5000), 32'h1);
    check("wr1020_awaddr", aw_q.size() > 0 ? aw_q[0] : 32'hFFFF_FFFF, 32'h1020);
    check("wr1020_wdata", w_q.size() > 0 ? w_q[0][31:0] : 32'hFFFF_FFFF, 32'h12345678);
    check("wr1020_wstrb", w_q.size() > 0 ? 32'(w_q[0][35:32]) : 32'hFFFF_FFFF, 32'hF);
    rd32("rd1020", 32'h1020, 32'h12345678);

    aw_wait = 3; w_wait = 0;
    wr32("wr1024", 32'h1024, 32'hDEADBEEF);
    aw_wait = 0; w_wait = 3;
    wr32("wr1028", 32'h1028, 32'hCAFEBABE);
    aw_wait = 2; w_wait = 2;
    wr32("wr102c_0", 32'h102C, 32'h00000000);
    rd32("rd102c_0", 32'h102C, 32'h00000000);
    wr32("wr102c_f", 32'h102C, 32'hFFFFFFFF);
    aw_wait = 0; w_wait = 0;
    rd32("rd1024", 32'h1024, 32'hDEADBEEF);
    rd32("rd1028", 32'h1028, 32'hCAFEBABE);
    rd32("rd102c_f", 32'h102C, 32'hFFFFFFFF);

    run("burst4", 8'hE3, 32'h1020,
        mk(8'h00, 6'd16, 3'd4, 128'hFFFFFFFF_CAFEBABE_DEADBEEF_12345678), 5000);
    check("burst4_nar", 32'(ar_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("burst4_ar%0d", i), ar_q.size() > i ? ar_q[i] : 32'hFFFF_FFFF, 32'h1020 + 32'(4*i));

    write_data[0] = 8'hAB;
    run("wr8", 8'h00, 32'h1025, mk(8'h00, 6'd0, 3'd0, 128'h0), 5000);
    check("wr8_w", w_q.size() > 0 ? 32'(w_q[0][35:8]) : 32'hFFFF_FFFF, 32'h20000AB);
    run("rd8", 8'h80, 32'h1025, mk(8'h00, 6'd1, 3'd0, 128'h0), 5000);
    check("rd8_byte", 32'(read_data[0]), 32'hAB);
    rd32("rd1024_b", 32'h1024, 32'hDEADABEF);

    write_data[0] = 8'h34; write_data[1] = 8'h12;
    run("wr16", 8'h10, 32'h102A, mk(8'h00, 6'd0, 3'd0, 128'h0), 5000);
    check("wr16_wdata", w_q.size() > 0 ? w_q[0][31:0] : 32'hFFFF_FFFF, 32'h12340000);
    check("wr16_wstrb", w_q.size() > 0 ? 32'(w_q[0][35:32]) : 32'hFFFF_FFFF, 32'hC);
    rd32("rd1028_h", 32'h1028, 32'h1234BABE);

    bresp_err = 1'b1;
    for (int k = 0; k < 8; k++) write_data[k] = 8'h5A;
    run("slverr", 8'h21, 32'h1030, mk(8'h01, 6'd0, 3'd0, 128'h0), 5000);
    check("slverr_naw", 32'(aw_q.size()), 32'd1);
    bresp_err = 1'b0;

    stall_ar = 1'b1;
    run("timeout", 8'hA0, 32'h1020, mk(8'h02, 6'd0, 3'd0, 128'h0), 5000);
    check("timeout_min", 32'(lat >= TMO), 32'h1);
    check("timeout_max", 32'(lat <= TMO + 8), 32'h1);
    stall_ar = 1'b0;
    rd32("rd_recover", 32'h1024, 32'hDEADABEF);

    for (int k = 0; k < 4; k++) write_data[k] = 8'h77;
`ifdef AXI4L_MASTER_ALIGN_CHECK_EN
    run("misalign", 8'h20, 32'h1022, mk(8'h03, 6'd0, 3'd0, 128'h0), 5000);
    check("misalign_naw", 32'(aw_q.size()), 32'd0);
`else
    run("misalign", 8'h20, 32'h1022, mk(8'h00, 6'd0, 3'd0, 128'h0), 5000);
    check("misalign_awaddr", aw_q.size() > 0 ? aw_q[0] : 32'hFFFF_FFFF, 32'h1020);
`endif

    run("illsize", 8'h30, 32'h1020, mk(8'h04, 6'd0, 3'd0, 128'h0), 5000);
    check("illsize_traffic", 32'(aw_q.size() + ar_q.size()), 32'd0);

    begin
      int d0;
      aw_wait = 20;
      @(negedge clk);
      cmd = 8'h20; addr = 32'h1020; start = 1'b1; d0 = done_cnt;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_busy", 32'(axi_if.awvalid), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_idle", 32'({axi_if.awvalid, axi_if.wvalid, done}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      aw_wait = 0;
      repeat (10) @(negedge clk);
      check("midrst_nodone", 32'(done_cnt - d0), 32'd0);
    end
    rd32("rd_after_rst", 32'h1024, 32'hDEADABEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
